// File: rtl/load_store_ctrl.sv
// rtl/load_store_ctrl.sv - load/store sequencing FSM for a multicycle datapath
module load_store_ctrl #(
  parameter int         MEM_LAT  = 2,
  parameter logic [2:0] ADDR_SEL = 3'd1,
  parameter logic [2:0] PC_SEL   = 3'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [1:0] addr_lo,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] mem_addr_sel,
  output logic       mem_w,
  output logic       mds_w,
  output logic [2:0] wdata_sel,
  output logic [1:0] ld_sel,
  output logic       reg_w
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    RD_WAIT = 3'd2,
    CAPTURE = 3'd3,
    WB      = 3'd4,
    WRITE   = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [2:0] OP_LW = 3'b000;
  localparam logic [2:0] OP_LH = 3'b001;
  localparam logic [2:0] OP_LB = 3'b010;
  localparam logic [2:0] OP_SW = 3'b011;
  localparam logic [2:0] OP_SH = 3'b100;
  localparam logic [2:0] OP_SB = 3'b101;

  localparam logic [2:0] CNT_LOAD = 3'(MEM_LAT - 1);

  state_t     state, next_state;
  logic [2:0] op_q;
  logic [1:0] addr_q;
  logic [2:0] cnt;

  function automatic logic is_reject(input logic [2:0] o, input logic [1:0] a);
    case (o)
      OP_LW, OP_SW: is_reject = (a != 2'b00);
      OP_LH, OP_SH: is_reject = a[0];
      OP_LB, OP_SB: is_reject = 1'b0;
      default:      is_reject = 1'b1;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= 3'b000;
      addr_q <= 2'b00;
      cnt    <= 3'd0;
    end else begin
      state <= next_state;
      // The request is captured even when rejected so DONE can report err from it.
      if (state == IDLE && start) begin
        op_q   <= op;
        addr_q <= addr_lo;
      end
      if (state != RD_WAIT && next_state == RD_WAIT)
        cnt <= CNT_LOAD;
      else if (state == RD_WAIT && cnt != 3'd0)
        cnt <= cnt - 3'd1;
    end
  end

  always_comb begin
    next_state   = state;
    busy         = 1'b1;
    done         = 1'b0;
    err          = 1'b0;
    mem_addr_sel = PC_SEL;
    mem_w        = 1'b0;
    mds_w        = 1'b0;
    wdata_sel    = 3'd0;
    ld_sel       = 2'd0;
    reg_w        = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start)
          next_state = is_reject(op, addr_lo) ? DONE : ADDR;
      end
      ADDR: begin
        mem_addr_sel = ADDR_SEL;
        next_state   = (op_q == OP_SW) ? WRITE : RD_WAIT;
      end
      RD_WAIT: begin
        mem_addr_sel = ADDR_SEL;
        if (cnt == 3'd0)
          next_state = CAPTURE;
      end
      CAPTURE: begin
        mem_addr_sel = ADDR_SEL;
        mds_w        = 1'b1;
        // Sub-word stores read the word first so the write can merge into it.
        next_state   = (op_q == OP_SH || op_q == OP_SB) ? WRITE : WB;
      end
      WB: begin
        reg_w = 1'b1;
        case (op_q)
          OP_LH:   ld_sel = 2'd1;
          OP_LB:   ld_sel = 2'd2;
          default: ld_sel = 2'd0;
        endcase
        next_state = DONE;
      end
      WRITE: begin
        mem_addr_sel = ADDR_SEL;
        mem_w        = 1'b1;
        case (op_q)
          OP_SW:   wdata_sel = 3'd2;
          OP_SH:   wdata_sel = 3'd1;
          default: wdata_sel = 3'd0;
        endcase
        next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        err        = is_reject(op_q, addr_q);
        next_state = IDLE;
      end
      default: begin
        busy       = 1'b0;
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: doc/load_store_ctrl.md
LOAD_STORE_CTRL -- requirements
Module: load_store_ctrl

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2: memory read wait cycles after the address is driven, legal range 1..7.
REQ-002 SHALL have parameter ADDR_SEL, default 3'd1: mem_addr_sel code that selects the computed data address.
REQ-003 SHALL have parameter PC_SEL, default 3'd0: mem_addr_sel code that selects PC while idle.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1  request strobe, sampled only in IDLE.
REQ-007 SHALL have port op  in  3  operation: 000 lw, 001 lh, 010 lb, 011 sw, 100 sh, 101 sb, 110/111 invalid.
REQ-008 SHALL have port addr_lo  in  2  low two address bits, used for the alignment check.
REQ-009 SHALL have port busy  out  1  high in every state except IDLE.
REQ-010 SHALL have port done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port err  out  1  asserted with done when a request is rejected.
REQ-012 SHALL have port mem_addr_sel  out  3  memory address mux select.
REQ-013 SHALL have port mem_w  out  1  memory write enable.
REQ-014 SHALL have port mds_w  out  1  memory data register load.
REQ-015 SHALL have port wdata_sel  out  3  write-data mux select: 0 byte merge, 1 half merge, 2 full word.
REQ-016 SHALL have port ld_sel  out  2  load extend select: 0 word, 1 half sign-extend, 2 byte sign-extend.
REQ-017 SHALL have port reg_w  out  1  register file write enable.

Function
REQ-018 SHALL implement these states: IDLE, ADDR, RD_WAIT, CAPTURE, WB, WRITE, DONE.
REQ-019 SHALL, in IDLE with start=1, latch op and addr_lo and go to ADDR, or go to DONE with an error flag when the request is rejected.
REQ-020 SHALL reject a request when op is 110 or 111, when lw/sw has addr_lo!=00, or when lh/sh has addr_lo[0]=1.
REQ-021 SHALL, on a rejected request, spend exactly one DONE cycle with done=1 and err=1, and never assert mem_w, mds_w or reg_w.
REQ-022 SHALL ignore start and any change on op/addr_lo while busy=1.
REQ-023 SHALL transition from ADDR to WRITE for sw, and to RD_WAIT for all other ops.
REQ-024 SHALL stay in RD_WAIT for exactly MEM_LAT cycles, counted by a 3-bit down-counter loaded with MEM_LAT-1 on entry, and then go to CAPTURE.
REQ-025 SHALL assert mds_w=1 for exactly one cycle in CAPTURE, then go to WB for loads or to WRITE for sh/sb.
REQ-026 SHALL, in WB, drive reg_w=1 and ld_sel (lw=0, lh=1, lb=2) for one cycle, then go to DONE.
REQ-027 SHALL, in WRITE, drive mem_w=1 and wdata_sel (sw=2, sh=1, sb=0) for one cycle, then go to DONE.
REQ-028 SHALL, in DONE, drive done=1 for one cycle, with err=1 only for rejected requests, then go to IDLE.
REQ-029 SHALL drive mem_addr_sel=ADDR_SEL in ADDR, RD_WAIT, CAPTURE and WRITE, and mem_addr_sel=PC_SEL in all other states.
REQ-030 SHALL drive mem_w, mds_w, reg_w, ld_sel and wdata_sel to 0 outside their named states.
REQ-031 SHALL produce these latencies, counting ADDR as cycle 1: done in cycle MEM_LAT+4 for loads and sh/sb; done in cycle 3 for sw; done in the cycle after acceptance for rejects.
REQ-032 SHALL accept a new start in the IDLE cycle that directly follows DONE; back-to-back requests need no gap cycle.

Reset
REQ-033 SHALL, on reset=1, immediately enter IDLE and clear the counter and latched op, and hold busy, done, err, mem_w, mds_w, reg_w, ld_sel and wdata_sel at 0 with mem_addr_sel=PC_SEL.
REQ-034 SHALL suppress any pending write or register writeback when reset arrives mid-operation, and SHALL require a fresh start after reset deasserts.

Verification
REQ-035 SHALL verify lw: op=000, addr_lo=00, MEM_LAT=2 -> mds_w in cycle 4, reg_w=1 with ld_sel=0 in cycle 5, done in cycle 6, mem_w never asserted.
REQ-036 SHALL verify sb: op=101, addr_lo=11 -> mds_w in cycle 4, mem_w=1 with wdata_sel=0 in cycle 5, done in cycle 6, reg_w never asserted.
REQ-037 SHALL verify sw: op=011, addr_lo=00 -> mem_w=1 with wdata_sel=2 in cycle 2, done in cycle 3, mds_w never asserted.
REQ-038 SHALL verify rejects: op=000 with addr_lo=10, and op=111 -> done=1 and err=1 in the next cycle, mem_w/mds_w/reg_w stay 0.
REQ-039 SHALL verify reset mid-operation: sh (op=100, addr_lo=00) with reset pulsed during RD_WAIT -> outputs reach reset values without waiting for a clock edge, no mem_w, busy=0.
REQ-040 SHALL verify busy handling: start held high through a lh, with a second op issued mid-operation -> the second op is ignored, the next request is accepted in the cycle after done, and a MEM_LAT=1 build gives done in cycle 5.
